// File: rtl/hyper_traffic_gen.sv
// hyper_traffic_gen: LFSR-addressed write/read memory traffic generator with in-order response checking.
module hyper_traffic_gen #(
    parameter int          AddrWidth      = 32,
    parameter int          DataWidth      = 64,
    parameter int          MaxOutstanding = 8,
    parameter logic [31:0] Seed           = 32'hACE1_2357
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   mode_i,
    input  logic [31:0]            num_txns_i,
    input  logic [AddrWidth-1:0]   base_addr_i,
    input  logic [AddrWidth-1:0]   addr_mask_i,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic                   req_we_o,
    output logic [AddrWidth-1:0]   req_addr_o,
    output logic [DataWidth-1:0]   req_wdata_o,
    output logic [DataWidth/8-1:0] req_be_o,
    input  logic                   rsp_valid_i,
    input  logic [DataWidth-1:0]   rsp_rdata_i,
    input  logic                   rsp_err_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [15:0]            err_cnt_o,
    output logic [AddrWidth-1:0]   first_err_addr_o
);
    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [31:0] Taps = 32'h8020_0003;
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(DataWidth / 8 - 1);

    typedef enum logic [2:0] {IDLE, WRITE, WDRAIN, READ, RDRAIN, PAIR, PDRAIN, DONE} state_t;
    state_t state, state_d;

    logic [31:0]          lfsr, num_txns, txn_cnt;
    logic [AddrWidth-1:0] base, mask;
    logic                 pair_rd, err_seen;
    logic [CW-1:0]        outstanding;
    logic [AddrWidth-1:0] fifo_addr [MaxOutstanding];
    logic                 fifo_we [MaxOutstanding];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 can_issue, go, hs, rsp_pop, rsp_bad, last, load, reseed, advance;

    function automatic logic [DataWidth-1:0] pattern(input logic [AddrWidth-1:0] a);
        return {(DataWidth / 32){32'(a) ^ Seed}};
    endfunction

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_addr_o  = base | (AddrWidth'(lfsr) & mask & AlignMask);
    assign req_wdata_o = pattern(req_addr_o);
    assign req_be_o    = '1;
    assign can_issue   = outstanding != CW'(MaxOutstanding);
    assign go          = can_issue && req_ready_i;
    assign hs          = req_valid_o && req_ready_i;
    assign rsp_pop     = rsp_valid_i && outstanding != '0;
    assign rsp_bad     = rsp_err_i || (!fifo_we[rd_ptr] && rsp_rdata_i != pattern(fifo_addr[rd_ptr]));
    assign last        = txn_cnt == num_txns - 32'd1;
    assign busy_o      = state != IDLE && state != DONE;
    assign done_o      = state == DONE;

    // State register
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state, request strobe and datapath control
    always_comb begin
        state_d     = state;
        req_valid_o = 1'b0;
        req_we_o    = 1'b0;
        load        = 1'b0;
        reseed      = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = (num_txns_i == '0) ? DONE : (mode_i ? PAIR : WRITE);
                end
            end
            WRITE: begin
                req_valid_o = can_issue;
                req_we_o    = 1'b1;
                advance     = go;
                if (go && last) state_d = WDRAIN;
            end
            WDRAIN: begin
                reseed = outstanding == '0;
                if (reseed) state_d = READ;
            end
            READ: begin
                req_valid_o = can_issue;
                advance     = go;
                if (go && last) state_d = RDRAIN;
            end
            PAIR: begin
                req_valid_o = can_issue;
                req_we_o    = !pair_rd;
                advance     = go && pair_rd;
                if (advance && last) state_d = PDRAIN;
            end
            RDRAIN, PDRAIN: if (outstanding == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Configuration latch, LFSR address stepping and pair phase
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            lfsr     <= Seed;
            num_txns <= '0;
            base     <= '0;
            mask     <= '0;
            txn_cnt  <= '0;
            pair_rd  <= 1'b0;
        end else if (load) begin
            lfsr     <= Seed;
            num_txns <= num_txns_i;
            base     <= base_addr_i;
            mask     <= addr_mask_i;
            txn_cnt  <= '0;
            pair_rd  <= 1'b0;
        end else if (reseed) begin
            lfsr    <= Seed;
            txn_cnt <= '0;
        end else begin
            if (advance) begin
                lfsr    <= (lfsr >> 1) ^ (lfsr[0] ? Taps : 32'h0);
                txn_cnt <= txn_cnt + 32'd1;
            end
            if (state == PAIR && hs) pair_rd <= !pair_rd;
        end
    end

    // Issue-order FIFO storage; every request is recorded so responses map to addresses
    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_addr[wr_ptr] <= req_addr_o;
            fifo_we[wr_ptr]   <= req_we_o;
        end
    end

    // FIFO pointers and outstanding count (equal to FIFO occupancy)
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (hs) wr_ptr <= bump(wr_ptr);
            if (rsp_pop) rd_ptr <= bump(rd_ptr);
            outstanding <= outstanding + CW'(hs) - CW'(rsp_pop);
        end
    end

    // Error counting; stray responses count but never capture an address
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            err_seen         <= 1'b0;
        end else if (load) begin
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            err_seen         <= 1'b0;
        end else if (rsp_valid_i && (!rsp_pop || rsp_bad)) begin
            if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
            if (rsp_pop && !err_seen) begin
                first_err_addr_o <= fifo_addr[rd_ptr];
                err_seen         <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hyper_traffic_gen.sv
// tb_hyper_traffic_gen: directed checks of address order, data, flow control and error reporting.
module tb_hyper_traffic_gen;
    localparam logic [31:0] SEED = 32'hACE1_2357;

    typedef struct {bit we; logic [31:0] addr;} req_t;
    typedef struct {bit we; logic [31:0] addr; int due;} pend_t;

    logic        clk_i = 0, rst_n = 1, start_i = 0, mode_i = 0;
    logic [31:0] num_txns_i = 0, base_addr_i = 0, addr_mask_i = 0;
    logic        req_valid_o, req_ready_i = 0, req_we_o;
    logic [31:0] req_addr_o;
    logic [63:0] req_wdata_o;
    logic [7:0]  req_be_o;
    logic        rsp_valid_i = 0, rsp_err_i = 0;
    logic [63:0] rsp_rdata_i = 0;
    logic        busy_o, done_o;
    logic [15:0] err_cnt_o;
    logic [31:0] first_err_addr_o;

    int checks = 0, errors = 0;
    int cyc = 0, lat = 2, rd_idx = 0, corrupt_rd = -1, n_req = 0, out_cnt = 0, max_out = 0, stab_bad = 0;
    bit bp = 0, err_all = 0, stall_prev = 0, saw_valid = 0;
    logic        s_we;
    logic [31:0] s_addr;
    logic [63:0] s_wdata;
    logic [31:0] exp_a [64];
    logic [31:0] got_q [$];
    req_t        exp_q [$];
    pend_t       pend [$];
    logic [63:0] mem [logic [31:0]];

    hyper_traffic_gen #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
        .num_txns_i(num_txns_i), .base_addr_i(base_addr_i), .addr_mask_i(addr_mask_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_we_o(req_we_o),
        .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .req_be_o(req_be_o),
        .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i), .rsp_err_i(rsp_err_i),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Expected request stream from the address formula with a reference LFSR
    task automatic build(input bit mode, input int n, input logic [31:0] base, input logic [31:0] mask);
        logic [31:0] l = SEED;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_a[i] = base | (l & mask & ~32'h7);
            l = {1'b0, l[31:1]} ^ ({32{l[0]}} & 32'h8020_0003);
        end
        for (int i = 0; i < n; i++) begin
            if (mode) begin
                exp_q.push_back('{1'b1, exp_a[i]});
                exp_q.push_back('{1'b0, exp_a[i]});
            end else exp_q.push_back('{1'b1, exp_a[i]});
        end
        if (!mode) for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, exp_a[i]});
    endtask

    // One clock: sample at negedge, check the request, model memory and drive responses
    task automatic cycle();
        req_t  e;
        pend_t p;
        logic [63:0] d;
        bit hs;
        @(negedge clk_i);
        cyc++;
        if (req_valid_o) saw_valid = 1;
        if (stall_prev && (!req_valid_o || req_addr_o !== s_addr || req_we_o !== s_we || req_wdata_o !== s_wdata))
            stab_bad++;
        req_ready_i = bp ? (cyc % 3 == 0) : 1'b1;
        hs = req_valid_o && req_ready_i;
        rsp_valid_i = 0;
        rsp_err_i = 0;
        rsp_rdata_i = 0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            rsp_valid_i = 1;
            rsp_err_i = err_all;
            if (!p.we) begin
                d = mem.exists(p.addr) ? mem[p.addr] : 64'h0;
                if (rd_idx == corrupt_rd) d[0] = ~d[0];
                rd_idx++;
                rsp_rdata_i = d;
            end
            out_cnt--;
        end
        if (hs) begin
            got_q.push_back(req_addr_o);
            if (exp_q.size() == 0) check("extra_req", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("req_we", req_we_o, e.we);
                check("req_addr", req_addr_o, e.addr);
                if (e.we) check("req_wdata", req_wdata_o, {2{e.addr ^ SEED}});
                check("req_be", req_be_o, 8'hFF);
            end
            if (req_we_o) mem[req_addr_o] = req_wdata_o;
            pend.push_back('{req_we_o, req_addr_o, cyc + lat});
            out_cnt++;
            n_req++;
        end
        if (out_cnt > max_out) max_out = out_cnt;
        stall_prev = req_valid_o && !req_ready_i;
        s_we = req_we_o;
        s_addr = req_addr_o;
        s_wdata = req_wdata_o;
    endtask

    task automatic start(input bit mode, input int n, input logic [31:0] base, input logic [31:0] mask);
        build(mode, n, base, mask);
        got_q.delete();
        rd_idx = 0;
        n_req = 0;
        max_out = 0;
        stab_bad = 0;
        mode_i = mode;
        num_txns_i = n;
        base_addr_i = base;
        addr_mask_i = mask;
        start_i = 1;
        cycle();
        start_i = 0;
    endtask

    task automatic finish_run();
        for (int k = 0; k < 3000 && !done_o; k++) cycle();
        check("done", done_o, 1);
        check("busy_done", busy_o, 0);
        check("exp_left", exp_q.size(), 0);
        check("pend_left", pend.size(), 0);
        check("stable", stab_bad, 0);
    endtask

    task automatic do_reset();
        rst_n = 1;
        pend.delete();
        exp_q.delete();
        out_cnt = 0;
        stall_prev = 0;
        cycle();
        check("rst_valid", req_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_cnt_o, 0);
        check("rst_first", first_err_addr_o, 0);
        rst_n = 0;
        cycle();
    endtask

    initial begin
        cycle();
        do_reset();

        // Mode 0, 16 addresses, ideal memory
        start(0, 16, 32'h8000_0000, 32'h0000_FFFF);
        check("busy_run", busy_o, 1);
        finish_run();
        check("a_err", err_cnt_o, 0);
        check("a_nreq", n_req, 32);
        check("a_addr0", got_q[0], 32'h8000_2350);
        check("a_addr1", got_q[1], 32'h8000_91A8);
        check("a_rd_order", got_q[16], 32'h8000_2350);

        // Stray response with nothing outstanding
        rsp_valid_i = 1;
        rsp_err_i = 0;
        cycle();
        cycle();
        check("orphan_cnt", err_cnt_o, 1);
        check("orphan_addr", first_err_addr_o, 0);

        // Mode 1 pairs, third read corrupted
        corrupt_rd = 2;
        start(1, 4, 32'h8000_0000, 32'h0000_FFFF);
        finish_run();
        corrupt_rd = -1;
        check("b_err", err_cnt_o, 1);
        check("b_first", first_err_addr_o, exp_a[2]);

        // Slow responses with backpressure, limit of two outstanding
        lat = 20;
        bp = 1;
        start(1, 4, 32'h1000_0000, 32'h0000_03FF);
        finish_run();
        check("c_max_out", max_out, 2);
        check("c_err", err_cnt_o, 0);
        lat = 2;
        bp = 0;

        // Zero transactions
        saw_valid = 0;
        start(0, 0, 32'h8000_0000, 32'h0000_FFFF);
        check("d_done", done_o, 1);
        cycle();
        cycle();
        check("d_no_valid", saw_valid, 0);
        check("d_nreq", n_req, 0);

        // Reset during READ, then restart with the same configuration
        start(0, 8, 32'h4000_0000, 32'h0000_0FFF);
        for (int k = 0; k < 500 && n_req < 10; k++) cycle();
        check("e_in_read", n_req, 10);
        do_reset();
        start(0, 8, 32'h4000_0000, 32'h0000_0FFF);
        finish_run();
        check("e_err", err_cnt_o, 0);
        check("e_addr0", got_q[0], exp_a[0]);

        // Error flag on every response
        err_all = 1;
        start(0, 8, 32'h8000_0000, 32'h0000_FFFF);
        finish_run();
        err_all = 0;
        check("f_err", err_cnt_o, 16);
        check("f_first", first_err_addr_o, exp_a[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hyper_traffic_gen.md
HYPER_TRAFFIC_GEN -- requirements
Module: hyper_traffic_gen

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, request address width.
REQ-002 SHALL have parameter DataWidth, default 64, data width; legal values are 32, 64 or 128.
REQ-003 SHALL have parameter MaxOutstanding, default 8, maximum number of issued requests without a response (1..16).
REQ-004 SHALL have parameter Seed, default 32'hACE1_2357, LFSR seed and data scramble key; it SHALL be nonzero.
REQ-005 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start_i  input  1  one-cycle start pulse; sampled only in IDLE or DONE.
REQ-008 SHALL have port mode_i  input  1  0 = write all, then read all; 1 = write/read pairs.
REQ-009 SHALL have port num_txns_i  input  32  number of addresses to exercise; latched at start.
REQ-010 SHALL have port base_addr_i  input  AddrWidth  region base; latched at start.
REQ-011 SHALL have port addr_mask_i  input  AddrWidth  region offset mask (2^n-1); latched at start.
REQ-012 SHALL have ports req_valid_o/req_ready_i  out/in  1  request handshake.
REQ-013 SHALL have ports req_we_o 1, req_addr_o AddrWidth, req_wdata_o DataWidth, req_be_o DataWidth/8  output  request payload.
REQ-014 SHALL have ports rsp_valid_i 1, rsp_rdata_i DataWidth, rsp_err_i 1  input  in-order responses for writes and reads.
REQ-015 SHALL have outputs busy_o 1, done_o 1, err_cnt_o 16, first_err_addr_o AddrWidth  status.

Function
REQ-016 SHALL implement FSM IDLE, WRITE, WDRAIN, READ, RDRAIN, PAIR, PDRAIN, DONE.
REQ-017 SHALL, on start_i in IDLE/DONE, latch the configuration, reload the 32-bit Galois LFSR (taps 32,22,2,1) with Seed, clear err_cnt_o and first_err_addr_o, and enter WRITE (mode 0) or PAIR (mode 1).
REQ-018 SHALL, on start_i with num_txns_i = 0, go directly to DONE without issuing requests.
REQ-019 SHALL form req_addr_o = base | (lfsr[AddrWidth-1:0] & mask & ~(DataWidth/8-1)) and advance the LFSR only on an accepted address that completes its use (write in mode 0; read in mode 1).
REQ-020 SHALL drive req_wdata_o = (addr XOR Seed) replicated to DataWidth and req_be_o = all ones.
REQ-021 SHALL hold req_valid_o and the payload stable until req_ready_i; it SHALL NOT drop valid without a handshake.
REQ-022 SHALL deassert req_valid_o while the outstanding count equals MaxOutstanding; count +1 on handshake, -1 on rsp_valid_i, unchanged if both occur in the same cycle.
REQ-023 SHALL, in WRITE, issue num_txns writes, then enter WDRAIN until outstanding = 0, then reseed the LFSR and enter READ.
REQ-024 SHALL, in READ, issue num_txns reads, push each read address into a MaxOutstanding-deep FIFO, then enter RDRAIN until outstanding = 0, then DONE.
REQ-025 SHALL, in PAIR, issue a write then a read to the same address per transaction (read address pushed into the FIFO), then enter PDRAIN and DONE.
REQ-026 SHALL compare each read response against the pattern of the FIFO-head address; a mismatch or rsp_err_i on any response increments err_cnt_o, saturating at 16'hFFFF.
REQ-027 SHALL capture first_err_addr_o on the first error only (the write response address uses the issue-order FIFO entry for writes as well).
REQ-028 SHALL ignore rsp_valid_i when outstanding = 0, counting it as one error with no address capture.
REQ-029 SHALL assert busy_o in every state except IDLE/DONE, and done_o only in DONE, with no combinational path from inputs.

Reset
REQ-030 SHALL, while rst_n = 1, force IDLE, req_valid_o = 0, busy_o = 0, done_o = 0, err_cnt_o = 0, first_err_addr_o = 0, outstanding = 0, FIFO empty, LFSR = Seed.
REQ-031 SHALL abandon any in-flight transaction on reset mid-operation; responses arriving after reset release are handled per REQ-028.

Verification
REQ-032 SHALL pass this case: mode 0, num_txns = 16, base = 32'h8000_0000, mask = 32'hFFFF, ideal memory -> 16 writes then 16 reads with identical address order, done_o = 1, err_cnt_o = 0.
REQ-033 SHALL pass this case: mode 1, num_txns = 4, memory corrupts bit 0 of the 3rd read -> err_cnt_o = 1, first_err_addr_o = 3rd pair address.
REQ-034 SHALL pass this case: MaxOutstanding = 2, responses delayed 20 cycles -> never more than 2 outstanding, req_valid_o stable under backpressure.
REQ-035 SHALL pass this case: start_i with num_txns = 0 -> done_o the next cycle, no req_valid_o.
REQ-036 SHALL pass this case: rst_n pulsed during READ, then restart with the same config -> identical address sequence, err_cnt_o = 0.
REQ-037 SHALL pass this case: rsp_err_i = 1 on every response for num_txns = 8, mode 0 -> err_cnt_o = 16.
